// File: rtl/mc_datapath_pkg.sv
// Shared types and encodings for the multicycle datapath: FSM states, ALU and PC-select codes,
// and the control-word layout {ps, da, sa, sb, fs, reg_w, mem_rd, mem_w, sel_b, wb_sel}.
package mc_datapath_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam logic [4:0] FS_AND  = 5'd0;
   localparam logic [4:0] FS_OR   = 5'd1;
   localparam logic [4:0] FS_ADD  = 5'd2;
   localparam logic [4:0] FS_SUB  = 5'd3;
   localparam logic [4:0] FS_XOR  = 5'd4;
   localparam logic [4:0] FS_PASS = 5'd5;
   localparam logic [4:0] FS_SHL  = 5'd6;
   localparam logic [4:0] FS_SHR  = 5'd7;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_BR   = 2'b10;
   localparam logic [1:0] PS_JMP  = 2'b11;

   localparam int CW_WB_SEL = 0;
   localparam int CW_SEL_B  = 1;
   localparam int CW_MEM_W  = 2;
   localparam int CW_MEM_RD = 3;
   localparam int CW_REG_W  = 4;
   localparam int CW_FS_LSB = 5;
   localparam int CW_SB_LSB = 10;

   function automatic int cw_sa_lsb(input int reg_n);
      return CW_SB_LSB + $clog2(reg_n);
   endfunction

   function automatic int cw_da_lsb(input int reg_n);
      return CW_SB_LSB + 2 * $clog2(reg_n);
   endfunction

   function automatic int cw_ps_lsb(input int reg_n);
      return CW_SB_LSB + 3 * $clog2(reg_n);
   endfunction

   function automatic int cw_width(input int reg_n);
      return CW_SB_LSB + 3 * $clog2(reg_n) + 2;
   endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// Bus bundle between the datapath (master) and its memories, decoder and observers (slave).
interface mc_datapath_if #(
   parameter int DATA_W  = 64,
   parameter int REG_N   = 32,
   parameter int PC_W    = 64,
   parameter int DMEM_AW = 8
);
   import mc_datapath_pkg::*;

   localparam int CW_W = cw_width(REG_N);

   logic                imem_req;
   logic [PC_W-1:0]     imem_addr;
   logic                imem_valid;
   logic [31:0]         imem_data;
   logic [31:0]         instruction;
   logic [CW_W-1:0]     cw;
   logic [DATA_W-1:0]   k;
   logic                dmem_req;
   logic                dmem_we;
   logic [DMEM_AW-1:0]  dmem_addr;
   logic [DATA_W-1:0]   dmem_wdata;
   logic                dmem_ack;
   logic [DATA_W-1:0]   dmem_rdata;
   logic [DATA_W-1:0]   alu_out;
   logic [3:0]          status;
   logic [PC_W-1:0]     pc_out;
   logic                retire;

   modport master (
      output imem_req, imem_addr, instruction, dmem_req, dmem_we, dmem_addr, dmem_wdata,
             alu_out, status, pc_out, retire,
      input  imem_valid, imem_data, cw, k, dmem_ack, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr, instruction, dmem_req, dmem_we, dmem_addr, dmem_wdata,
             alu_out, status, pc_out, retire,
      output imem_valid, imem_data, cw, k, dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/mc_datapath_regfile.sv
// REG_N x DATA_W register file: two combinational reads, one synchronous write;
// the top register always reads as zero and ignores writes.
module mc_regfile #(
   parameter int DATA_W = 64,
   parameter int REG_N  = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [$clog2(REG_N)-1:0]   i_ra_a,
   input  logic [$clog2(REG_N)-1:0]   i_ra_b,
   input  logic                       i_we,
   input  logic [$clog2(REG_N)-1:0]   i_wa,
   input  logic [DATA_W-1:0]          i_wd,
   output logic [DATA_W-1:0]          o_rd_a,
   output logic [DATA_W-1:0]          o_rd_b
);
   localparam int RA_W = $clog2(REG_N);
   localparam logic [RA_W-1:0] ZERO_IDX = RA_W'(REG_N - 1);

   logic [DATA_W-1:0] r_mem [REG_N];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < REG_N; i++) r_mem[i] <= '0;
      end else if (i_we && (i_wa != ZERO_IDX)) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   assign o_rd_a = (i_ra_a == ZERO_IDX) ? '0 : r_mem[i_ra_a];
   assign o_rd_b = (i_ra_b == ZERO_IDX) ? '0 : r_mem[i_ra_b];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath: FETCH -> DECODE -> EXEC -> (MEM) -> WB with handshaked memories.
// Optional MC_DATAPATH_PERF_EN adds cycle_cnt / instr_cnt counters.
module mc_datapath
   import mc_datapath_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int REG_N   = 32,
   parameter int PC_W    = 64,
   parameter int DMEM_AW = 8
) (
   input  logic clock,
   input  logic reset,
   mc_datapath_if.master bus
`ifdef MC_DATAPATH_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
`endif
);
   localparam int RA_W   = $clog2(REG_N);
   localparam int CW_W   = cw_width(REG_N);
   localparam int SH_W   = $clog2(DATA_W);
   localparam int MA_LSB = (DATA_W == 64) ? 3 : 2;

   state_t             r_state, w_state_nxt;
   logic [PC_W-1:0]    r_pc, w_pc_nxt;
   logic [31:0]        r_instr;
   logic [CW_W-1:0]    r_cw;
   logic [DATA_W-1:0]  r_k, r_alu_out, r_mdata;
   logic [3:0]         r_status;

   logic [1:0]         w_ps;
   logic [RA_W-1:0]    w_da, w_sa, w_sb;
   logic [4:0]         w_fs;
   logic               w_reg_w, w_mem_rd, w_mem_w, w_sel_b, w_wb_sel, w_rf_we;
   logic [DATA_W-1:0]  w_rd_a, w_rd_b, w_op_b, w_wb_data;
   logic [DATA_W+3:0]  w_alu;

   assign w_ps     = r_cw[cw_ps_lsb(REG_N) +: 2];
   assign w_da     = r_cw[cw_da_lsb(REG_N) +: RA_W];
   assign w_sa     = r_cw[cw_sa_lsb(REG_N) +: RA_W];
   assign w_sb     = r_cw[CW_SB_LSB +: RA_W];
   assign w_fs     = r_cw[CW_FS_LSB +: 5];
   assign w_reg_w  = r_cw[CW_REG_W];
   assign w_mem_rd = r_cw[CW_MEM_RD];
   assign w_mem_w  = r_cw[CW_MEM_W];
   assign w_sel_b  = r_cw[CW_SEL_B];
   assign w_wb_sel = r_cw[CW_WB_SEL];

   // Result packed as {V, C, N, Z, F}; carry/overflow only meaningful for ADD/SUB.
   function automatic logic [DATA_W+3:0] alu_eval(input logic [4:0] fs,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic [DATA_W:0]   sum;
      logic [DATA_W-1:0] f;
      logic              c, v;
      sum = '0;
      f   = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (fs)
         FS_AND:  f = a & b;
         FS_OR:   f = a | b;
         FS_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            f   = sum[DATA_W-1:0];
            c   = sum[DATA_W];
            v   = (a[DATA_W-1] == b[DATA_W-1]) && (f[DATA_W-1] != a[DATA_W-1]);
         end
         FS_SUB: begin
            sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
            f   = sum[DATA_W-1:0];
            c   = sum[DATA_W];
            v   = (a[DATA_W-1] != b[DATA_W-1]) && (f[DATA_W-1] != a[DATA_W-1]);
         end
         FS_XOR:  f = a ^ b;
         FS_PASS: f = b;
         FS_SHL:  f = a << b[SH_W-1:0];
         FS_SHR:  f = a >> b[SH_W-1:0];
         default: f = '0;
      endcase
      return {v, c, f[DATA_W-1], (f == '0), f};
   endfunction

   mc_regfile #(
      .DATA_W (DATA_W),
      .REG_N  (REG_N)
   ) u_regfile (
      .clock  (clock),
      .reset  (reset),
      .i_ra_a (w_sa),
      .i_ra_b (w_sb),
      .i_we   (w_rf_we),
      .i_wa   (w_da),
      .i_wd   (w_wb_data),
      .o_rd_a (w_rd_a),
      .o_rd_b (w_rd_b)
   );

   assign w_op_b    = w_sel_b ? r_k : w_rd_b;
   assign w_alu     = alu_eval(w_fs, w_rd_a, w_op_b);
   assign w_wb_data = w_wb_sel ? r_mdata : r_alu_out;
   assign w_rf_we   = (r_state == WB) && w_reg_w;

   always_comb begin
      w_pc_nxt = r_pc;
      case (w_ps)
         PS_INC:  w_pc_nxt = r_pc + PC_W'(4);
         PS_BR:   w_pc_nxt = r_pc + PC_W'(4) + {r_k[PC_W-3:0], 2'b00};
         PS_JMP:  w_pc_nxt = w_rd_a[PC_W-1:0];
         default: w_pc_nxt = r_pc;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= FETCH;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FETCH:   if (bus.imem_valid) w_state_nxt = DECODE;
         DECODE:  w_state_nxt = EXEC;
         EXEC:    w_state_nxt = (w_mem_rd || w_mem_w) ? MEM : WB;
         MEM:     if (bus.dmem_ack) w_state_nxt = WB;
         WB:      w_state_nxt = FETCH;
         default: w_state_nxt = FETCH;
      endcase
   end

   // Requests are masked while reset is held so nothing leaks out during reset.
   always_comb begin
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
      bus.retire   = 1'b0;
      if (!reset) begin
         case (r_state)
            FETCH: bus.imem_req = 1'b1;
            MEM: begin
               bus.dmem_req = 1'b1;
               bus.dmem_we  = w_mem_w;
            end
            WB:      bus.retire = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc      <= '0;
         r_instr   <= '0;
         r_cw      <= '0;
         r_k       <= '0;
         r_alu_out <= '0;
         r_status  <= '0;
         r_mdata   <= '0;
      end else begin
         case (r_state)
            FETCH:  if (bus.imem_valid) r_instr <= bus.imem_data;
            DECODE: begin
               r_cw <= bus.cw;
               r_k  <= bus.k;
            end
            EXEC: begin
               r_alu_out <= w_alu[DATA_W-1:0];
               r_status  <= w_alu[DATA_W+3:DATA_W];
            end
            MEM:     if (bus.dmem_ack && w_mem_rd && !w_mem_w) r_mdata <= bus.dmem_rdata;
            WB:      r_pc <= w_pc_nxt;
            default: ;
         endcase
      end
   end

   assign bus.imem_addr   = r_pc;
   assign bus.pc_out      = r_pc;
   assign bus.instruction = r_instr;
   assign bus.alu_out     = r_alu_out;
   assign bus.status      = r_status;
   assign bus.dmem_addr   = r_alu_out[MA_LSB +: DMEM_AW];
   assign bus.dmem_wdata  = w_rd_b;

`ifdef MC_DATAPATH_PERF_EN
   logic [31:0] r_cycle_cnt, r_instr_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (r_state == WB) r_instr_cnt <= r_instr_cnt + 32'd1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
   assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: acts as instruction memory, decoder and wait-state data memory,
// with a queue of expected per-instruction results compared at retire (MC_DATAPATH_PERF_EN aware).
module tb_mc_datapath;
   localparam int DATA_W  = 64;
   localparam int REG_N   = 32;
   localparam int PC_W    = 64;
   localparam int DMEM_AW = 8;
   localparam int CW_W    = 27;

   typedef struct {
      logic [63:0] alu;
      logic [3:0]  st;
      logic [63:0] pc;
      int          lat;
      int          req;
   } exp_t;

   exp_t        sb_q[$];
   logic        clock, reset;
   int          checks = 0;
   int          errors = 0;
   int          slot = 0;
   int          retires = 0;
   logic [63:0] cur_pc = '0;
   logic [CW_W-1:0] prog_cw [16];
   logic [63:0] prog_k [16];
   logic [63:0] dmem_m [256];

   mc_datapath_if #(.DATA_W(DATA_W), .REG_N(REG_N), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) bus ();

   assign bus.cw = prog_cw[bus.instruction[3:0]];
   assign bus.k  = prog_k[bus.instruction[3:0]];

`ifdef MC_DATAPATH_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   mc_datapath #(.DATA_W(DATA_W), .REG_N(REG_N), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
`ifdef MC_DATAPATH_PERF_EN
      ,
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [CW_W-1:0] mk(input logic [1:0] ps, input int da, input int sa,
                                          input int sb, input logic [4:0] fs, input logic rw,
                                          input logic mrd, input logic mw, input logic selb,
                                          input logic wbs);
      return {ps, 5'(da), 5'(sa), 5'(sb), fs, rw, mrd, mw, selb, wbs};
   endfunction

   task automatic run_instr(input string tag, input logic [CW_W-1:0] c, input logic [63:0] kk,
                            input int iwait, input int dwait, input logic [63:0] e_alu,
                            input logic [3:0] e_st, input logic [63:0] e_pc,
                            input logic [63:0] e_daddr, input logic [63:0] e_wdata);
      exp_t e, got;
      int   lat, reqc, dcnt, budget;
      logic is_mem, is_wr;
      is_mem = c[3] | c[2];
      is_wr  = c[2];
      e.alu  = e_alu;
      e.st   = e_st;
      e.pc   = e_pc;
      e.lat  = 4 + iwait + (is_mem ? dwait + 1 : 0);
      e.req  = is_mem ? dwait + 1 : 0;
      sb_q.push_back(e);

      prog_cw[slot] = c;
      prog_k[slot]  = kk;
      lat  = 1;
      reqc = 0;
      dcnt = 0;
      for (int i = 0; i < iwait; i++) begin
         chk({tag, ":imem_req_wait"}, 64'(bus.imem_req), 64'd1);
         chk({tag, ":imem_addr_wait"}, bus.imem_addr, cur_pc);
         tick();
         lat++;
      end
      chk({tag, ":imem_req"}, 64'(bus.imem_req), 64'd1);
      chk({tag, ":imem_addr"}, bus.imem_addr, cur_pc);
      bus.imem_valid = 1'b1;
      bus.imem_data  = 32'(slot);
      tick();
      bus.imem_valid = 1'b0;
      bus.imem_data  = 32'hDEAD_BEEF;
      lat++;
      chk({tag, ":instruction"}, 64'(bus.instruction), 64'(slot));

      budget = 40;
      while (bus.retire !== 1'b1 && budget > 0) begin
         if (bus.dmem_req === 1'b1) begin
            reqc++;
            chk({tag, ":dmem_addr"}, 64'(bus.dmem_addr), e_daddr);
            chk({tag, ":dmem_we"}, 64'(bus.dmem_we), 64'(is_wr));
            if (is_wr) chk({tag, ":dmem_wdata"}, bus.dmem_wdata, e_wdata);
            if (dcnt == dwait) begin
               bus.dmem_ack = 1'b1;
               if (is_wr) dmem_m[bus.dmem_addr] = bus.dmem_wdata;
               else       bus.dmem_rdata = dmem_m[bus.dmem_addr];
            end else begin
               dcnt++;
            end
         end
         tick();
         bus.dmem_ack   = 1'b0;
         bus.dmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
         lat++;
         budget--;
      end
      chk({tag, ":retire_in_budget"}, 64'(budget > 0), 64'd1);

      got = sb_q.pop_front();
      chk({tag, ":alu_out"}, bus.alu_out, got.alu);
      chk({tag, ":status"}, 64'(bus.status), 64'(got.st));
      chk({tag, ":latency"}, 64'(lat), 64'(got.lat));
      chk({tag, ":req_cycles"}, 64'(reqc), 64'(got.req));
      tick();
      retires++;
      chk({tag, ":retire_pulse"}, 64'(bus.retire), 64'd0);
      chk({tag, ":pc"}, bus.pc_out, got.pc);
      cur_pc = got.pc;
      slot   = (slot + 1) % 16;
   endtask

   initial begin
      reset          = 1'b1;
      bus.imem_valid = 1'b0;
      bus.imem_data  = '0;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = '0;
      for (int i = 0; i < 16; i++) begin
         prog_cw[i] = '0;
         prog_k[i]  = '0;
      end
      for (int i = 0; i < 256; i++) dmem_m[i] = '0;
      repeat (3) tick();
      chk("rst:pc", bus.pc_out, 64'd0);
      chk("rst:imem_req", 64'(bus.imem_req), 64'd0);
      chk("rst:dmem_req", 64'(bus.dmem_req), 64'd0);
      chk("rst:retire", 64'(bus.retire), 64'd0);
      chk("rst:alu_out", bus.alu_out, 64'd0);
      chk("rst:status", 64'(bus.status), 64'd0);
      chk("rst:instruction", 64'(bus.instruction), 64'd0);
      reset = 1'b0;
      #1;

      run_instr("add_r1", mk(2'b01, 1, 31, 0, 5'd2, 1, 0, 0, 1, 0), 64'd5, 3, 0,
                64'd5, 4'b0000, 64'h4, 0, 0);
      run_instr("sub_r2", mk(2'b01, 2, 1, 1, 5'd3, 1, 0, 0, 0, 0), 64'd0, 0, 0,
                64'd0, 4'b0101, 64'h8, 0, 0);
      run_instr("ld_max", mk(2'b01, 4, 31, 0, 5'd5, 1, 0, 0, 1, 0), 64'h7FFF_FFFF_FFFF_FFFF, 1, 0,
                64'h7FFF_FFFF_FFFF_FFFF, 4'b0000, 64'hC, 0, 0);
      run_instr("add_ovf", mk(2'b01, 5, 4, 0, 5'd2, 1, 0, 0, 1, 0), 64'd1, 0, 0,
                64'h8000_0000_0000_0000, 4'b1010, 64'h10, 0, 0);
      run_instr("store", mk(2'b01, 0, 31, 1, 5'd2, 0, 0, 1, 1, 0), 64'h18, 0, 2,
                64'h18, 4'b0000, 64'h14, 64'd3, 64'd5);
      run_instr("load_r3", mk(2'b01, 3, 31, 0, 5'd2, 1, 1, 0, 1, 1), 64'h18, 0, 2,
                64'h18, 4'b0000, 64'h18, 64'd3, 0);
      run_instr("rd_r3", mk(2'b01, 0, 31, 3, 5'd5, 0, 0, 0, 0, 0), 64'd0, 0, 0,
                64'd5, 4'b0000, 64'h1C, 0, 0);
      run_instr("rd_r2", mk(2'b01, 0, 31, 2, 5'd5, 0, 0, 0, 0, 0), 64'd0, 0, 0,
                64'd0, 4'b0001, 64'h20, 0, 0);
      run_instr("branch", mk(2'b10, 0, 31, 0, 5'd5, 0, 0, 0, 1, 0), 64'hFFFF_FFFF_FFFF_FFFE, 0, 0,
                64'hFFFF_FFFF_FFFF_FFFE, 4'b0010, 64'h1C, 0, 0);
      run_instr("set_r6", mk(2'b01, 6, 31, 0, 5'd5, 1, 0, 0, 1, 0), 64'h100, 0, 0,
                64'h100, 4'b0000, 64'h20, 0, 0);
      run_instr("jump_wr31", mk(2'b11, 31, 6, 0, 5'd5, 1, 0, 0, 1, 0), 64'h55, 0, 0,
                64'h55, 4'b0000, 64'h100, 0, 0);
      run_instr("rd_r31", mk(2'b01, 0, 31, 31, 5'd5, 0, 0, 0, 0, 0), 64'd0, 0, 0,
                64'd0, 4'b0001, 64'h104, 0, 0);
      run_instr("shl", mk(2'b01, 7, 1, 0, 5'd6, 1, 0, 0, 1, 0), 64'd4, 0, 0,
                64'h50, 4'b0000, 64'h108, 0, 0);
      run_instr("shr", mk(2'b01, 0, 4, 0, 5'd7, 0, 0, 0, 1, 0), 64'd60, 0, 0,
                64'h7, 4'b0000, 64'h10C, 0, 0);
      run_instr("xor", mk(2'b01, 0, 1, 0, 5'd4, 0, 0, 0, 1, 0), 64'hF, 0, 0,
                64'hA, 4'b0000, 64'h110, 0, 0);
      run_instr("or", mk(2'b01, 0, 1, 0, 5'd1, 0, 0, 0, 1, 0), 64'hA, 0, 0,
                64'hF, 4'b0000, 64'h114, 0, 0);
      run_instr("and", mk(2'b01, 0, 1, 0, 5'd0, 0, 0, 0, 1, 0), 64'h6, 0, 0,
                64'h4, 4'b0000, 64'h118, 0, 0);
      run_instr("fs_undef", mk(2'b01, 0, 1, 0, 5'd9, 0, 0, 0, 1, 0), 64'h3, 0, 0,
                64'h0, 4'b0001, 64'h11C, 0, 0);
      run_instr("hold", mk(2'b00, 0, 31, 0, 5'd5, 0, 0, 0, 1, 0), 64'h1, 0, 0,
                64'h1, 4'b0000, 64'h11C, 0, 0);
      run_instr("rd_r7", mk(2'b01, 0, 31, 7, 5'd5, 0, 0, 0, 0, 0), 64'd0, 0, 0,
                64'h50, 4'b0000, 64'h120, 0, 0);

      // Reset in the middle of a stalled store, then a stale ack.
      prog_cw[slot] = mk(2'b01, 0, 31, 1, 5'd2, 0, 0, 1, 1, 0);
      prog_k[slot]  = 64'h18;
      bus.imem_valid = 1'b1;
      bus.imem_data  = 32'(slot);
      tick();
      bus.imem_valid = 1'b0;
      repeat (2) tick();
      chk("mrst:dmem_req_before", 64'(bus.dmem_req), 64'd1);
      reset = 1'b1;
      tick();
      chk("mrst:dmem_req", 64'(bus.dmem_req), 64'd0);
      chk("mrst:pc", bus.pc_out, 64'd0);
      chk("mrst:retire", 64'(bus.retire), 64'd0);
      reset = 1'b0;
      bus.dmem_ack = 1'b1;
      #1;
      chk("mrst:imem_req", 64'(bus.imem_req), 64'd1);
      tick();
      bus.dmem_ack = 1'b0;
      chk("mrst:stale_ack_fetch", 64'(bus.imem_req), 64'd1);
      chk("mrst:stale_ack_dmem", 64'(bus.dmem_req), 64'd0);
      chk("mrst:stale_ack_retire", 64'(bus.retire), 64'd0);
      slot    = (slot + 1) % 16;
      cur_pc  = '0;
      retires = 0;
      run_instr("post_rst_r1", mk(2'b01, 0, 31, 1, 5'd5, 0, 0, 0, 0, 0), 64'd0, 0, 0,
                64'd0, 4'b0001, 64'h4, 0, 0);
`ifdef MC_DATAPATH_PERF_EN
      chk("perf:instr_cnt", 64'(instr_cnt), 64'(retires));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
Parametrised multicycle successor to the single-cycle 64-bit datapath. It contains the register file, ALU, status flags and PC, and sequences every instruction through an FSM. Instruction and data memories are external and use req/valid handshakes, so wait-state memories are tolerated. An external combinational decoder turns the fetched instruction into a control word and immediate.

Parameters:
DATA_W, 64, datapath, register, ALU and RAM data width (legal: 32 or 64)
REG_N, 32, register count (power of 2, >=4); register REG_N-1 reads as zero, writes ignored
PC_W, 64, program counter width (<= DATA_W)
DMEM_AW, 8, data memory word address width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch byte address (= pc)
imem_valid  in  1  instruction word valid
imem_data  in  32  instruction word
instruction  out  32  latched instruction, drives the external decoder
cw  in  CW_W  control word from the decoder (layout in package)
k  in  DATA_W  immediate from the decoder
dmem_req  out  1  data access request
dmem_we  out  1  1 = write
dmem_addr  out  DMEM_AW  word address = alu_out[DMEM_AW+2:3] (DATA_W 64) or [DMEM_AW+1:2] (DATA_W 32)
dmem_wdata  out  DATA_W  = register B
dmem_ack  in  1  access complete; rdata valid on the same cycle for reads
dmem_rdata  in  DATA_W  read data
alu_out  out  DATA_W  latched ALU result
status  out  4  {V,C,N,Z} latched when the ALU executes
pc_out  out  PC_W  current PC
retire  out  1  one-cycle pulse per completed instruction

Behaviour:
- Reset (synchronous, active-high):
  - pc_out=0, state=FETCH, all registers=0.
  - alu_out, status and instruction cleared to 0.
  - imem_req, dmem_req and retire are 0.
  - Reset mid-access drops the request the next edge; a late ack is ignored.
- FSM states: FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH.
  - FETCH: imem_req=1 held until imem_valid. On valid, latch instruction and go to DECODE. imem_valid without req is ignored.
  - DECODE: one cycle; latch cw and k.
  - EXEC: read A=R[sa], B = sel_b ? k : R[sb]. Compute F and latch into alu_out and status.
    - If mem_rd or mem_w, go to MEM; otherwise go to WB.
  - MEM: dmem_req=1, dmem_we=mem_w, held stable until dmem_ack. On a read ack, latch dmem_rdata. mem_rd and mem_w both set is treated as a write.
  - WB:
    - If reg_w, write R[da] = wb_sel ? mem data : alu_out.
    - Update PC by ps:
      - 00 hold
      - 01 pc+4
      - 10 pc+4+(k<<2)
      - 11 R[sa] truncated to PC_W
    - retire=1 for this cycle.
- Minimum latency is 4 cycles without memory wait states, 5 with MEM. Each wait cycle adds 1.
- Register file has 2 combinational reads and 1 synchronous write. Writes to REG_N-1 are dropped.
- ALU, by fs:
  - 0 AND; 1 OR; 2 ADD; 3 SUB (A+~B+1); 4 XOR; 5 PASS_B
  - 6 SHL by B[log2(DATA_W)-1:0]; 7 logical SHR by the same amount
  - 8..31 give 0
- Flags:
  - Z = F==0; N = F[DATA_W-1].
  - C = carry out on ADD/SUB, else 0.
  - V = signed overflow on ADD/SUB, else 0.
  - Flags are updated only in EXEC.
- PC arithmetic is modulo 2^PC_W. Wrap-around is silent.

Optional Feature:
Macro MC_DATAPATH_PERF_EN.
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt counts every cycle out of reset.
  - instr_cnt counts retire pulses.
  - Both clear on reset and wrap at 2^32.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

Decomposition:
Package mc_datapath_pkg holds:
- state enum {FETCH, DECODE, EXEC, MEM, WB}
- fs opcode localparams
- ps encodings
- control word field offsets and CW_W as functions of REG_N: {ps[1:0], da, sa, sb, fs[4:0], reg_w, mem_rd, mem_w, sel_b, wb_sel}

One sub-module is natural: mc_regfile (REG_N x DATA_W, 2R1W, zero register). The ALU stays inline.

Test Plan:
- Reset, then fetch with imem_valid delayed 3 cycles -> imem_addr=0 held; DECODE entered the cycle after valid; retire at cycle 7.
- ADD with k=5 into R1=R31+k, then SUB R2=R1-R1 -> R1=5, status=0000; then R2=0, status Z=1, C=1.
- ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> alu_out=0x8000_0000_0000_0000, N=1, V=1, C=0.
- Store R1 with alu_out=0x18, dmem_ack delayed 2 cycles; then load to R3 -> dmem_addr=3, dmem_wdata=5, request held 3 cycles; R3=5.
- Branch ps=10, k=-2 at pc=0x20 -> pc=0x1C; ps=11 with R[sa]=0x100 -> pc=0x100; write to R31 leaves it reading 0.
- Reset asserted during MEM wait -> next cycle dmem_req=0, pc=0, state FETCH; a subsequent stale ack has no effect.
